// File: rtl/rv_bus_interconnect_pkg.sv
// rtl/rv_bus_interconnect_pkg.sv - shared target, state, size and address-map definitions
package rv_bus_interconnect_pkg;

    typedef enum logic [1:0] {
        TGT_NONE  = 2'd0,
        TGT_DMEM  = 2'd1,
        TGT_CLINT = 2'd2,
        TGT_UART  = 2'd3
    } target_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [31:0] DEF_DMEM_BASE  = 32'h8000_0000;
    localparam int          DEF_DMEM_SIZE  = 16384;
    localparam logic [31:0] DEF_CLINT_BASE = 32'h0200_0000;
    localparam logic [31:0] DEF_UART_BASE  = 32'h1000_0000;
    localparam int          CLINT_SIZE     = 65536;
    localparam int          UART_SIZE      = 8;

    localparam logic [2:0] SIZE_B = 3'd0;
    localparam logic [2:0] SIZE_H = 3'd1;
    localparam logic [2:0] SIZE_W = 3'd2;
    localparam logic [2:0] SIZE_D = 3'd3;

    // Low address bits that must be zero for an access of the given size.
    function automatic logic [2:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/rv_bus_interconnect_addr_decode.sv
// rtl/rv_bus_interconnect_addr_decode.sv - combinational address/size decoder (rv_bus_addr_decode)
module rv_bus_addr_decode
    import rv_bus_interconnect_pkg::*;
#(
    parameter int          XLEN       = 32,
    parameter logic [31:0] DMEM_BASE  = DEF_DMEM_BASE,
    parameter int          DMEM_SIZE  = DEF_DMEM_SIZE,
    parameter logic [31:0] CLINT_BASE = DEF_CLINT_BASE,
    parameter logic [31:0] UART_BASE  = DEF_UART_BASE
) (
    input  logic [XLEN-1:0] addr,
    input  logic [2:0]      size,
    output target_e         target,
    output logic            misaligned,
    output logic            unmapped
);

    logic dmem_hit;
    logic clint_hit;
    logic uart_hit;

    // Unsigned offset compare gives a half-open window without a separate lower-bound test.
    assign dmem_hit  = (addr - XLEN'(DMEM_BASE))  < XLEN'(DMEM_SIZE);
    assign clint_hit = (addr - XLEN'(CLINT_BASE)) < XLEN'(CLINT_SIZE);
    assign uart_hit  = (addr - XLEN'(UART_BASE))  < XLEN'(UART_SIZE);

    always_comb begin
        target = TGT_NONE;
        if (dmem_hit) begin
            target = TGT_DMEM;
        end else if (clint_hit) begin
            target = TGT_CLINT;
        end else if (uart_hit) begin
            target = TGT_UART;
        end
    end

    assign unmapped   = (target == TGT_NONE);
    assign misaligned = size[2] | (|(addr[2:0] & size_mask(size[1:0])));

endmodule

// File: rtl/rv_bus_interconnect.sv
// rtl/rv_bus_interconnect.sv - single-master DMEM/CLINT/UART interconnect; BUS_TIMEOUT_EN adds a BUSY watchdog
module rv_bus_interconnect
    import rv_bus_interconnect_pkg::*;
#(
    parameter int          XLEN           = 32,
    parameter logic [31:0] DMEM_BASE      = DEF_DMEM_BASE,
    parameter int          DMEM_SIZE      = DEF_DMEM_SIZE,
    parameter logic [31:0] CLINT_BASE     = DEF_CLINT_BASE,
    parameter logic [31:0] UART_BASE      = DEF_UART_BASE,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            m_req_valid,
    output logic            m_req_ready,
    input  logic [XLEN-1:0] m_req_addr,
    input  logic [XLEN-1:0] m_req_wdata,
    input  logic            m_req_we,
    input  logic [2:0]      m_req_size,
    output logic            m_rsp_valid,
    output logic [XLEN-1:0] m_rsp_rdata,
    output logic            m_rsp_err,
    output logic            dmem_req_valid,
    output logic [XLEN-1:0] dmem_req_addr,
    output logic [XLEN-1:0] dmem_req_wdata,
    output logic            dmem_req_we,
    output logic [2:0]      dmem_req_size,
    input  logic            dmem_req_ready,
    input  logic [XLEN-1:0] dmem_req_rdata,
    output logic            clint_req_valid,
    output logic [15:0]     clint_req_addr,
    output logic [63:0]     clint_req_wdata,
    output logic            clint_req_we,
    output logic [2:0]      clint_req_size,
    input  logic            clint_req_ready,
    input  logic [63:0]     clint_req_rdata,
    output logic            uart_req_valid,
    output logic [2:0]      uart_req_addr,
    output logic [7:0]      uart_req_wdata,
    output logic            uart_req_we,
    input  logic            uart_req_ready,
    input  logic [7:0]      uart_req_rdata
);

    state_e          state;
    logic [XLEN-1:0] cap_addr;
    logic [XLEN-1:0] cap_wdata;
    logic            cap_we;
    logic [2:0]      cap_size;
    target_e         cap_tgt;

    target_e         dec_tgt;
    logic            dec_mis;
    logic            dec_unm;
    logic            req_bad;
    logic            busy;
    logic            sel_ready;
    logic [XLEN-1:0] sel_rdata;
    logic [XLEN-1:0] clint_rdata_x;
    logic            tmo_hit;

    rv_bus_addr_decode #(
        .XLEN      (XLEN),
        .DMEM_BASE (DMEM_BASE),
        .DMEM_SIZE (DMEM_SIZE),
        .CLINT_BASE(CLINT_BASE),
        .UART_BASE (UART_BASE)
    ) u_decode (
        .addr      (m_req_addr),
        .size      (m_req_size),
        .target    (dec_tgt),
        .misaligned(dec_mis),
        .unmapped  (dec_unm)
    );

    assign req_bad = dec_unm | dec_mis | ((dec_tgt == TGT_UART) && (m_req_size != SIZE_B));
    assign busy        = (state == BUSY);
    assign m_req_ready = (state == IDLE);

    assign dmem_req_valid = busy && (cap_tgt == TGT_DMEM);
    assign dmem_req_addr  = cap_addr - XLEN'(DMEM_BASE);
    assign dmem_req_wdata = cap_wdata;
    assign dmem_req_we    = cap_we;
    assign dmem_req_size  = cap_size;

    // A 32-bit core sees the 64-bit CLINT registers as two word lanes selected by addr[2].
    assign clint_req_valid = busy && (cap_tgt == TGT_CLINT);
    assign clint_req_addr  = cap_addr[15:0];
    assign clint_req_wdata = (XLEN == 32) ? 64'({cap_wdata, cap_wdata}) : 64'(cap_wdata);
    assign clint_req_we    = cap_we;
    assign clint_req_size  = cap_size;
    assign clint_rdata_x   = (XLEN == 32)
                           ? XLEN'(cap_addr[2] ? clint_req_rdata[63:32] : clint_req_rdata[31:0])
                           : XLEN'(clint_req_rdata);

    assign uart_req_valid = busy && (cap_tgt == TGT_UART);
    assign uart_req_addr  = cap_addr[2:0];
    assign uart_req_wdata = cap_wdata[7:0];
    assign uart_req_we    = cap_we;

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        case (cap_tgt)
            TGT_DMEM:  begin sel_ready = dmem_req_ready;  sel_rdata = dmem_req_rdata;        end
            TGT_CLINT: begin sel_ready = clint_req_ready; sel_rdata = clint_rdata_x;         end
            TGT_UART:  begin sel_ready = uart_req_ready;  sel_rdata = XLEN'(uart_req_rdata); end
            default:   ;
        endcase
    end

`ifdef BUS_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TW-1:0] tmo_cnt;
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cap_addr    <= '0;
            cap_wdata   <= '0;
            cap_we      <= 1'b0;
            cap_size    <= '0;
            cap_tgt     <= TGT_NONE;
            m_rsp_valid <= 1'b0;
            m_rsp_err   <= 1'b0;
            m_rsp_rdata <= '0;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
        end else begin
            m_rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (m_req_valid) begin
                        cap_addr  <= m_req_addr;
                        cap_wdata <= m_req_wdata;
                        cap_we    <= m_req_we;
                        cap_size  <= m_req_size;
                        cap_tgt   <= req_bad ? TGT_NONE : dec_tgt;
`ifdef BUS_TIMEOUT_EN
                        tmo_cnt   <= '0;
`endif
                        if (req_bad) begin
                            state       <= RESP;
                            m_rsp_valid <= 1'b1;
                            m_rsp_err   <= 1'b1;
                            m_rsp_rdata <= '0;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
`ifdef BUS_TIMEOUT_EN
                    tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    if (sel_ready) begin
                        state       <= RESP;
                        m_rsp_valid <= 1'b1;
                        m_rsp_err   <= 1'b0;
                        m_rsp_rdata <= sel_rdata;
                    end else if (tmo_hit) begin
                        state       <= RESP;
                        m_rsp_valid <= 1'b1;
                        m_rsp_err   <= 1'b1;
                        m_rsp_rdata <= '0;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_bus_interconnect.sv
// tb/tb_rv_bus_interconnect.sv - directed scoreboard bench for rv_bus_interconnect
module tb_rv_bus_interconnect;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_req_valid;
    logic        m_req_ready;
    logic [31:0] m_req_addr;
    logic [31:0] m_req_wdata;
    logic        m_req_we;
    logic [2:0]  m_req_size;
    logic        m_rsp_valid;
    logic [31:0] m_rsp_rdata;
    logic        m_rsp_err;
    logic        dmem_req_valid;
    logic [31:0] dmem_req_addr;
    logic [31:0] dmem_req_wdata;
    logic        dmem_req_we;
    logic [2:0]  dmem_req_size;
    logic        dmem_req_ready;
    logic [31:0] dmem_req_rdata;
    logic        clint_req_valid;
    logic [15:0] clint_req_addr;
    logic [63:0] clint_req_wdata;
    logic        clint_req_we;
    logic [2:0]  clint_req_size;
    logic        clint_req_ready;
    logic [63:0] clint_req_rdata;
    logic        uart_req_valid;
    logic [2:0]  uart_req_addr;
    logic [7:0]  uart_req_wdata;
    logic        uart_req_we;
    logic        uart_req_ready;
    logic [7:0]  uart_req_rdata;

    int checks   = 0;
    int failures = 0;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    rv_bus_interconnect #(
        .XLEN          (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .m_req_valid    (m_req_valid),
        .m_req_ready    (m_req_ready),
        .m_req_addr     (m_req_addr),
        .m_req_wdata    (m_req_wdata),
        .m_req_we       (m_req_we),
        .m_req_size     (m_req_size),
        .m_rsp_valid    (m_rsp_valid),
        .m_rsp_rdata    (m_rsp_rdata),
        .m_rsp_err      (m_rsp_err),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_addr  (dmem_req_addr),
        .dmem_req_wdata (dmem_req_wdata),
        .dmem_req_we    (dmem_req_we),
        .dmem_req_size  (dmem_req_size),
        .dmem_req_ready (dmem_req_ready),
        .dmem_req_rdata (dmem_req_rdata),
        .clint_req_valid(clint_req_valid),
        .clint_req_addr (clint_req_addr),
        .clint_req_wdata(clint_req_wdata),
        .clint_req_we   (clint_req_we),
        .clint_req_size (clint_req_size),
        .clint_req_ready(clint_req_ready),
        .clint_req_rdata(clint_req_rdata),
        .uart_req_valid (uart_req_valid),
        .uart_req_addr  (uart_req_addr),
        .uart_req_wdata (uart_req_wdata),
        .uart_req_we    (uart_req_we),
        .uart_req_ready (uart_req_ready),
        .uart_req_rdata (uart_req_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // tgt: 1 = DMEM, 2 = CLINT, 3 = UART. others=1 drives non-selected readies high, selected low.
    task automatic set_ready(input int tgt, input logic others);
        dmem_req_ready  = (tgt == 1) ? ~others : others;
        clint_req_ready = (tgt == 2) ? ~others : others;
        uart_req_ready  = (tgt == 3) ? ~others : others;
    endtask

    task automatic check_fields(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic we, input logic [2:0] size, input int tgt);
        chk({tag, ".valids"}, {dmem_req_valid, clint_req_valid, uart_req_valid},
            {61'd0, tgt == 1, tgt == 2, tgt == 3});
        chk({tag, ".no_rsp"}, m_rsp_valid, 1'b0);
        case (tgt)
            1: chk({tag, ".dmem"}, {dmem_req_addr, dmem_req_wdata[27:0], dmem_req_we, dmem_req_size},
                   {addr - 32'h8000_0000, wdata[27:0], we, size});
            2: begin
                chk({tag, ".clint_addr"}, {clint_req_addr, clint_req_we, clint_req_size},
                    {addr[15:0], we, size});
                chk({tag, ".clint_wdata"}, clint_req_wdata, {wdata, wdata});
            end
            default: chk({tag, ".uart"}, {uart_req_addr, uart_req_wdata, uart_req_we},
                         {addr[2:0], wdata[7:0], we});
        endcase
    endtask

    task automatic run_txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic we, input logic [2:0] size, input int tgt, input int wait_n,
                           input logic [63:0] srdata, input logic [31:0] exp_rdata, input logic exp_err);
        int lat;
        logic [32:0] item;
        chk({tag, ".req_ready"}, m_req_ready, 1'b1);
        m_req_valid = 1'b1;
        m_req_addr  = addr;
        m_req_wdata = wdata;
        m_req_we    = we;
        m_req_size  = size;
        exp_q.push_back({exp_err, exp_rdata});
        @(negedge clk);
        // Scramble the master bus so the slave fields must come from captured state.
        m_req_valid = 1'b0;
        m_req_addr  = 32'hFFFF_FFF0;
        m_req_wdata = ~wdata;
        m_req_we    = ~we;
        m_req_size  = 3'd7;
        lat = 1;
        dmem_req_rdata  = srdata[31:0];
        clint_req_rdata = srdata;
        uart_req_rdata  = srdata[7:0];
        if (exp_err) begin
            chk({tag, ".quiet"}, {dmem_req_valid, clint_req_valid, uart_req_valid}, 64'd0);
        end else begin
            for (int i = 0; i < wait_n; i++) begin
                check_fields(tag, addr, wdata, we, size, tgt);
                set_ready(tgt, 1'b1);
                @(negedge clk);
                lat++;
            end
            check_fields(tag, addr, wdata, we, size, tgt);
            set_ready(tgt, 1'b0);
            @(negedge clk);
            lat++;
            set_ready(0, 1'b0);
        end
        for (int i = 0; i < 8 && !m_rsp_valid; i++) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".rsp_seen"}, m_rsp_valid, 1'b1);
        chk({tag, ".latency"}, lat, exp_err ? 1 : wait_n + 2);
        chk({tag, ".sb_depth"}, exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            item = exp_q.pop_front();
            chk({tag, ".rdata"}, m_rsp_rdata, item[31:0]);
            chk({tag, ".err"}, m_rsp_err, item[32]);
        end
        @(negedge clk);
        chk({tag, ".pulse_end"}, {m_rsp_valid, m_req_ready}, 2'b01);
    endtask

    initial begin
        int rsp_seen;
        int lat;
        logic [32:0] item;
        reset           = 1'b1;
        m_req_valid     = 1'b0;
        m_req_addr      = '0;
        m_req_wdata     = '0;
        m_req_we        = 1'b0;
        m_req_size      = '0;
        dmem_req_ready  = 1'b0;
        dmem_req_rdata  = '0;
        clint_req_ready = 1'b0;
        clint_req_rdata = '0;
        uart_req_ready  = 1'b0;
        uart_req_rdata  = '0;
        repeat (2) @(negedge clk);
        chk("reset.ready", m_req_ready, 1'b1);
        chk("reset.rsp", {m_rsp_valid, m_rsp_err, m_rsp_rdata}, 64'd0);
        chk("reset.valids", {dmem_req_valid, clint_req_valid, uart_req_valid}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_txn("dmem_rd",     32'h8000_0010, 32'h0,         1'b0, 3'd2, 1, 0, 64'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        run_txn("dmem_wr_top", 32'h8000_3FFC, 32'hCAFE_F00D, 1'b1, 3'd2, 1, 1, 64'h0,         32'h0,         1'b0);
        run_txn("dmem_byte",   32'h8000_0003, 32'h0,         1'b0, 3'd0, 1, 0, 64'h77,        32'h77,        1'b0);
        run_txn("dmem_edge",   32'h8000_4000, 32'h0,         1'b0, 3'd2, 1, 0, 64'h0,         32'h0,         1'b1);
        run_txn("clint_wr",    32'h0200_4000, 32'h100,       1'b1, 3'd2, 2, 0, 64'h0,         32'h0,         1'b0);
        run_txn("clint_rd_hi", 32'h0200_4004, 32'h0,         1'b0, 3'd2, 2, 2, 64'h1122_3344_5566_7788, 32'h1122_3344, 1'b0);
        run_txn("clint_rd_lo", 32'h0200_4000, 32'h0,         1'b0, 3'd2, 2, 0, 64'h1122_3344_5566_7788, 32'h5566_7788, 1'b0);
        run_txn("uart_wr",     32'h1000_0000, 32'h41,        1'b1, 3'd0, 3, 3, 64'h0,         32'h0,         1'b0);
        run_txn("uart_rd",     32'h1000_0005, 32'h0,         1'b0, 3'd0, 3, 0, 64'hFFFF_FFFF_FFFF_FF5A, 32'h5A, 1'b0);
        run_txn("uart_half",   32'h1000_0000, 32'h0,         1'b0, 3'd1, 3, 0, 64'h0,         32'h0,         1'b1);
        run_txn("uart_edge",   32'h1000_0008, 32'h0,         1'b0, 3'd0, 3, 0, 64'h0,         32'h0,         1'b1);
        run_txn("unmapped",    32'h4000_0000, 32'h0,         1'b0, 3'd2, 0, 0, 64'h0,         32'h0,         1'b1);
        run_txn("mis_half",    32'h8000_0001, 32'h0,         1'b0, 3'd1, 1, 0, 64'h0,         32'h0,         1'b1);
        run_txn("mis_word",    32'h8000_0002, 32'h0,         1'b0, 3'd2, 1, 0, 64'h0,         32'h0,         1'b1);

        // Reset while a CLINT access is waiting on its slave.
        m_req_valid = 1'b1;
        m_req_addr  = 32'h0200_0000;
        m_req_wdata = 32'h1;
        m_req_we    = 1'b1;
        m_req_size  = 3'd2;
        @(negedge clk);
        m_req_valid = 1'b0;
        chk("rst_mid.busy", clint_req_valid, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid.dropped", {clint_req_valid, m_rsp_valid, m_req_ready}, 3'b001);
        reset    = 1'b0;
        rsp_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (m_rsp_valid) rsp_seen++;
        end
        chk("rst_mid.no_rsp", rsp_seen, 0);

`ifdef BUS_TIMEOUT_EN
        m_req_valid = 1'b1;
        m_req_addr  = 32'h8000_0020;
        m_req_we    = 1'b0;
        m_req_size  = 3'd2;
        exp_q.push_back({1'b1, 32'h0});
        @(negedge clk);
        m_req_valid = 1'b0;
        lat = 1;
        for (int i = 0; i < 32 && !m_rsp_valid; i++) begin
            @(negedge clk);
            lat++;
        end
        chk("tmo.rsp_seen", m_rsp_valid, 1'b1);
        chk("tmo.latency", lat, 5);
        chk("tmo.slave_off", dmem_req_valid, 1'b0);
        chk("tmo.sb_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            item = exp_q.pop_front();
            chk("tmo.rsp", {m_rsp_err, m_rsp_rdata}, item);
        end
        @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rv_bus_interconnect.md
Name: rv_bus_interconnect

Overview:
- Single-master, three-slave memory-mapped interconnect between the pipelined core's data port and the SoC peripherals (DMEM, CLINT, UART).
- Decodes each request by address and forwards it to exactly one slave.
- Holds the slave request until that slave completes, then returns one registered response to the core.
- Replaces the tied-off peripheral request ports in rv_soc, so software can program MTIMECMP/MSIP and drive the UART.

Parameters:
- XLEN, 32, master data/address width (32 or 64).
- DMEM_BASE, 32'h8000_0000, DMEM base address.
- DMEM_SIZE, 16384, DMEM window size in bytes (power of two).
- CLINT_BASE, 32'h0200_0000, CLINT base address; window is 64 KiB.
- UART_BASE, 32'h1000_0000, UART base address; window is 8 bytes.
- TIMEOUT_CYCLES, 256, watchdog limit (used only with BUS_TIMEOUT_EN).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- m_req_valid  in  1  core request valid.
- m_req_ready  out  1  interconnect can accept a request.
- m_req_addr  in  XLEN  byte address.
- m_req_wdata  in  XLEN  write data.
- m_req_we  in  1  1 = write.
- m_req_size  in  3  funct3-style size: 0 = B, 1 = H, 2 = W, 3 = D.
- m_rsp_valid  out  1  response valid, one-cycle pulse.
- m_rsp_rdata  out  XLEN  read data.
- m_rsp_err  out  1  access fault: unmapped, misaligned or timeout.
- dmem_req_valid, dmem_req_addr[XLEN], dmem_req_wdata[XLEN], dmem_req_we, dmem_req_size[3]  out  DMEM request.
- dmem_req_ready  in  1  DMEM done; dmem_req_rdata[XLEN] is valid in that cycle.
- dmem_req_rdata  in  XLEN  DMEM read data.
- clint_req_valid, clint_req_addr[16], clint_req_wdata[64], clint_req_we, clint_req_size[3]  out  CLINT request.
- clint_req_ready  in  1  CLINT done.
- clint_req_rdata  in  64  CLINT read data.
- uart_req_valid, uart_req_addr[3], uart_req_wdata[8], uart_req_we  out  UART request.
- uart_req_ready  in  1  UART done.
- uart_req_rdata  in  8  UART read data.

Behaviour:
- Clocking: one clock, clk. Reset is synchronous, active-high, port name `reset`.
- Reset values: state IDLE; m_req_ready=1; m_rsp_valid=0, m_rsp_err=0, m_rsp_rdata=0; all *_req_valid=0; captured request registers 0.
- FSM states: IDLE, BUSY, RESP.
- IDLE: m_req_ready=1.
  - On m_req_valid, capture addr, wdata, we, size and the decoded target.
  - Mapped and aligned request: go to BUSY.
  - Otherwise: go to RESP with err=1 and rdata=0.
- BUSY:
  - Assert the selected slave's req_valid. Drive its fields from the captured registers, stable until ready.
  - When that slave's req_ready=1, latch rdata and go to RESP.
- RESP: m_rsp_valid=1 for exactly one cycle, then IDLE. The core must accept the response; there is no response backpressure.
- Latency: accept at cycle N, slave valid at N+1, zero-wait slave ready at N+1, response at N+2. Unmapped or misaligned requests respond at N+1.
- Throughput: one outstanding transaction. m_req_ready=0 in BUSY and RESP.
- Decode is half-open [base, base+size). Overlapping windows are illegal; DMEM has priority.
- Misaligned means addr is not a multiple of 2^size. This is an error and no slave sees it.
- UART window accepts size B only; any other size is an error.
- CLINT addr = addr[15:0].
  - XLEN=32: clint wdata = {wdata, wdata}; rdata = addr[2] ? hi32 : lo32.
  - XLEN=64: data passes through.
- UART: wdata[7:0] forwarded; rdata zero-extended to XLEN.
- DMEM addr = addr - DMEM_BASE.
- Ready for a non-selected slave is ignored.
- Reset mid-transaction: the transaction is dropped with no response; slave valid is low in the cycle after the reset edge.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined: an 8+ bit counter clears on entry to BUSY and increments each BUSY cycle. When it reaches TIMEOUT_CYCLES, deassert slave valid and go to RESP with err=1, rdata=0.
- Not defined: BUSY waits indefinitely and the counter is not synthesised.

Decomposition:
- Shared package / `config/rv_config.vh`:
  - target encoding localparams TGT_NONE, TGT_DMEM, TGT_CLINT, TGT_UART;
  - FSM state encodings;
  - default base addresses;
  - size codes.
- One sub-module: rv_bus_addr_decode. Combinational: addr and size in; target, misaligned and unmapped flags out. Reused by a future instruction-side decoder.

Test Plan:
- Read DMEM at 0x8000_0010, size W, zero-wait slave returning 0xDEADBEEF -> dmem addr=0x10, rsp_valid at N+2, rdata=0xDEADBEEF, err=0.
- Write CLINT MTIMECMP lo at 0x0200_4000, wdata=0x100, XLEN=32 -> clint addr=0x4000, wdata=0x00000100_00000100, we=1. Read of 0x0200_4004 returns the upper 32 bits.
- UART byte write of 0x41 to 0x1000_0000 with ready delayed 3 cycles -> uart valid held 3 cycles with stable fields, then one rsp pulse, err=0.
- Read unmapped 0x4000_0000, plus a halfword at 0x8000_0001 -> no slave valid, rsp at N+1, err=1, rdata=0.
- Reset asserted while BUSY on a CLINT access -> clint valid=0 after the edge, no rsp, m_req_ready=1.
- With BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, DMEM ready never asserted -> err=1 response after 4 BUSY cycles.
